// File: rtl/mips_timer_array.sv
// N-channel timer/counter: shared prescaler, per-channel register bank,
// IDLE/LOAD/CNT/INT FSM and a sticky, maskable interrupt flag.

package mips_timer_pkg;
  typedef struct packed {
    logic        we;
    logic [1:0]  idx;
    logic [31:0] data;
  } tmr_req_t;
endpackage

// One timer channel: register bank, FSM and interrupt flag.
module mips_timer_ch
  import mips_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_i,
  input  logic        sel_i,
  input  tmr_req_t    req_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  state_e             st_q, st_d;
  logic               en_q, en_d, im_q, im_d, pend_q, pend_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   preset_q, preset_d, cnt_q, cnt_d;
  logic               wr, hw_set, hw_en_clr;
  logic               unused_data;

  assign wr          = sel_i & req_i.we;
  assign unused_data = ^req_i.data;
  assign irq_o       = pend_q & im_q;

  // Next-state: FSM sequencing first, then register writes layered on top.
  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    pend_d    = pend_q;
    hw_set    = 1'b0;
    hw_en_clr = 1'b0;
    // software disable parks the channel; COUNT and PEND are left alone
    if (st_q != S_IDLE && !en_q) begin
      st_d = S_IDLE;
    end else begin
      case (st_q)
        S_IDLE: if (en_q) st_d = S_LOAD;
        S_LOAD: begin
          cnt_d = (mode_q == 2'b10) ? '0 : preset_q;
          st_d  = S_CNT;
        end
        S_CNT: begin
          if (mode_q == 2'b10) begin
            if (tick_i) begin
              cnt_d  = cnt_q + 1'b1;
              hw_set = &cnt_q;
            end
          end else if (cnt_q == '0) begin
            st_d   = S_INT;
            hw_set = 1'b1;
          end else if (tick_i) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_INT: begin
          // only auto-reload rearms; every other mode behaves as one-shot
          if (mode_q == 2'b01) st_d = S_LOAD;
          else begin
            st_d      = S_IDLE;
            hw_en_clr = 1'b1;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
    if (wr && req_i.idx == 2'd0) begin
      en_d   = req_i.data[0];
      mode_d = req_i.data[2:1];
      im_d   = req_i.data[3];
    end else if (hw_en_clr) begin
      en_d = 1'b0;
    end
    if (wr && req_i.idx == 2'd1) preset_d = req_i.data[CNT_W-1:0];
    if (wr && req_i.idx == 2'd3 && req_i.data[0]) pend_d = 1'b0;
    // a hardware set in the same cycle as a W1C keeps the flag
    if (hw_set) pend_d = 1'b1;
  end

  // State and register bank update.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      preset_q <= '0;
      cnt_q    <= '0;
    end else begin
      st_q     <= st_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      pend_q   <= pend_d;
      preset_q <= preset_d;
      cnt_q    <= cnt_d;
    end
  end

  // Combinational register read, zero-extended.
  always_comb begin
    rdata_o = '0;
    case (req_i.idx)
      2'd0: rdata_o[3:0] = {im_q, mode_q, en_q};
      2'd1: rdata_o = 32'(preset_q);
      2'd2: rdata_o = 32'(cnt_q);
      2'd3: rdata_o[0] = pend_q;
      default: rdata_o = '0;
    endcase
  end
endmodule

// Top: address decode, shared prescaler, channel array and read mux.
module mips_timer_array
  import mips_timer_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int CNT_W    = 32,
  parameter  int PRESCALE = 1,
  localparam int AW       = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [NUM_CH-1:0] IRQ
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]            pre_q, pre_d;
  logic                     tick;
  logic [31:0]              ch_sel;
  tmr_req_t                 req;
  logic [NUM_CH-1:0][31:0]  lane_rd;

  assign ch_sel = 32'(Addr >> 2);
  assign req    = '{we: WE, idx: Addr[1:0], data: Din};
  assign tick   = (pre_q == PW'(PRESCALE - 1));
  assign pre_d  = tick ? '0 : pre_q + 1'b1;

  // Shared free-running prescaler 0..PRESCALE-1.
  always_ff @(posedge clk) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mips_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .tick_i  (tick),
      .sel_i   (ch_sel == i),
      .req_i   (req),
      .rdata_o (lane_rd[i]),
      .irq_o   (IRQ[i])
    );
  end

  // Read mux; channels past NUM_CH read as zero.
  always_comb begin
    Dout = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sel == 32'(i)) Dout = lane_rd[i];
  end
endmodule
